// File: rtl/mv_select_if.sv
// Bundle between pe_top (candidate SADs) and mv_select (motion vector result).
// The master side produces the candidate set and frame_start; the slave side
// (mv_select) returns the winning candidate, status and FSM state.
//
// Handshake: blk_ovalid is a one-cycle strobe with no ready signal. A set
// presented while mv_select reports busy is dropped and counted in drop_cnt.
// mv_vld is a one-cycle strobe. mv_idx/mv_x/mv_y/min_sad are valid with it and
// hold their values until the next strobe.
interface mv_select_if #(
    parameter int SAD_W = 32,
    parameter int CNT_W = 16
);
    logic             frame_start;
    logic             blk_ovalid;
    logic [SAD_W-1:0] blk0_o;
    logic [SAD_W-1:0] blk1_o;
    logic [SAD_W-1:0] blk2_o;
    logic [SAD_W-1:0] blk3_o;
    logic [SAD_W-1:0] blk4_o;
    logic [SAD_W-1:0] blk5_o;
    logic [SAD_W-1:0] blk6_o;
    logic [SAD_W-1:0] blk7_o;
    logic [SAD_W-1:0] blk8_o;
    logic [SAD_W-1:0] blk9_o;
    logic [SAD_W-1:0] blk10_o;
    logic [SAD_W-1:0] blk11_o;
    logic [SAD_W-1:0] blk12_o;
    logic [SAD_W-1:0] blk13_o;
    logic [SAD_W-1:0] blk14_o;
    logic [SAD_W-1:0] blk15_o;
    logic             mv_vld;
    logic [3:0]       mv_idx;
    logic [2:0]       mv_x;
    logic [2:0]       mv_y;
    logic [SAD_W-1:0] min_sad;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;
    logic [1:0]       fsm_state;

    modport master (
        output frame_start, blk_ovalid,
        output blk0_o, blk1_o, blk2_o, blk3_o, blk4_o, blk5_o, blk6_o, blk7_o,
        output blk8_o, blk9_o, blk10_o, blk11_o, blk12_o, blk13_o, blk14_o, blk15_o,
        input  mv_vld, mv_idx, mv_x, mv_y, min_sad, busy, drop_cnt, fsm_state
    );

    modport slave (
        input  frame_start, blk_ovalid,
        input  blk0_o, blk1_o, blk2_o, blk3_o, blk4_o, blk5_o, blk6_o, blk7_o,
        input  blk8_o, blk9_o, blk10_o, blk11_o, blk12_o, blk13_o, blk14_o, blk15_o,
        output mv_vld, mv_idx, mv_x, mv_y, min_sad, busy, drop_cnt, fsm_state
    );
endinterface

// File: rtl/mv_select.sv
// Minimum-SAD selector: captures 16 candidate SADs, scans them serially
// (one compare per cycle), and reports the winning index as a signed motion
// vector on a GRID_W x GRID_W search grid. Sets arriving mid-scan are dropped
// and counted per frame.
module mv_select #(
    parameter int SAD_W  = 32,
    parameter int GRID_W = 4,
    parameter int MV_OFS = 2,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    mv_select_if.slave  bus
);
    localparam int NCAND = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [SAD_W-1:0] cand [NCAND];
    logic [SAD_W-1:0] bank [NCAND];
    logic [SAD_W-1:0] run_min;
    logic [3:0]       run_idx;
    logic [3:0]       k;

    logic             accept;
    logic             drop;
    logic             last_step;
    logic [SAD_W-1:0] cur_sad;
    logic [SAD_W-1:0] nxt_min;
    logic [3:0]       nxt_idx;
    logic [2:0]       nxt_mv_x;
    logic [2:0]       nxt_mv_y;

    // Gather the individual candidate ports into an indexable array.
    assign cand[0]  = bus.blk0_o;
    assign cand[1]  = bus.blk1_o;
    assign cand[2]  = bus.blk2_o;
    assign cand[3]  = bus.blk3_o;
    assign cand[4]  = bus.blk4_o;
    assign cand[5]  = bus.blk5_o;
    assign cand[6]  = bus.blk6_o;
    assign cand[7]  = bus.blk7_o;
    assign cand[8]  = bus.blk8_o;
    assign cand[9]  = bus.blk9_o;
    assign cand[10] = bus.blk10_o;
    assign cand[11] = bus.blk11_o;
    assign cand[12] = bus.blk12_o;
    assign cand[13] = bus.blk13_o;
    assign cand[14] = bus.blk14_o;
    assign cand[15] = bus.blk15_o;

    // A set is taken when idle or in the result cycle; anything during a scan is dropped.
    assign accept    = bus.blk_ovalid && (state == S_IDLE || state == S_OUT);
    assign drop      = bus.blk_ovalid && (state == S_SCAN);
    assign last_step = (k == 4'd15);

    assign bus.busy      = (state == S_SCAN);
    assign bus.fsm_state = state;

    // Maps a grid coordinate to a 3-bit signed offset from the search centre.
    function automatic logic [2:0] to_mv(input int coord);
        int v;
        v = coord - MV_OFS;
        return v[2:0];
    endfunction

    // One scan step: strict less-than so ties keep the earlier (lower) index.
    always_comb begin
        cur_sad  = bank[k];
        nxt_min  = run_min;
        nxt_idx  = run_idx;
        if (cur_sad < run_min) begin
            nxt_min = cur_sad;
            nxt_idx = k;
        end
        nxt_mv_x = to_mv(int'(nxt_idx) % GRID_W);
        nxt_mv_y = to_mv(int'(nxt_idx) / GRID_W);
    end

    // Capture bank: loaded only on an accepted set, untouched by drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCAND; i++) begin
                bank[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NCAND; i++) begin
                bank[i] <= cand[i];
            end
        end
    end

    // Control FSM plus running minimum and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            k           <= 4'd0;
            run_min     <= '0;
            run_idx     <= 4'd0;
            bus.mv_vld  <= 1'b0;
            bus.mv_idx  <= 4'd0;
            bus.mv_x    <= 3'd0;
            bus.mv_y    <= 3'd0;
            bus.min_sad <= '0;
        end else begin
            bus.mv_vld <= 1'b0;
            case (state)
                S_IDLE, S_OUT: begin
                    if (accept) begin
                        run_min <= cand[0];
                        run_idx <= 4'd0;
                        k       <= 4'd1;
                        state   <= S_SCAN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    run_min <= nxt_min;
                    run_idx <= nxt_idx;
                    k       <= k + 4'd1;
                    if (last_step) begin
                        state       <= S_OUT;
                        bus.mv_vld  <= 1'b1;
                        bus.mv_idx  <= nxt_idx;
                        bus.mv_x    <= nxt_mv_x;
                        bus.mv_y    <= nxt_mv_y;
                        bus.min_sad <= nxt_min;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-frame drop counter; frame_start restarts it, counting a coincident drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.drop_cnt <= '0;
        end else if (bus.frame_start) begin
            bus.drop_cnt <= drop ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (drop && bus.drop_cnt != CNT_MAX) begin
            bus.drop_cnt <= bus.drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mv_select.sv
// Bench for mv_select: directed scenarios plus a few random sets. A scoreboard
// queue holds the expected result and arrival cycle of every accepted set.
module tb_mv_select;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    logic [41:0] exp_q[$];
    int          exp_cyc[$];

    mv_select_if bus ();

    mv_select dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: first strictly-smallest candidate, offset from grid centre.
    function automatic logic [41:0] model(input logic [31:0] s[16]);
        int best;
        int x;
        int y;
        logic [3:0] bi;
        logic [2:0] bx;
        logic [2:0] by;
        best = 0;
        for (int i = 1; i < 16; i++) begin
            if (s[i] < s[best]) best = i;
        end
        x  = (best % 4) - 2;
        y  = (best / 4) - 2;
        bi = best[3:0];
        bx = x[2:0];
        by = y[2:0];
        return {bi, bx, by, s[best]};
    endfunction

    // Monitor: every mv_vld must match the oldest expected entry and arrive on time.
    always @(negedge clk) begin
        if (rst_n && bus.mv_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_mv_vld at cycle %0d idx=%0d", cyc, bus.mv_idx);
            end else begin
                logic [41:0] e;
                int ec;
                e  = exp_q.pop_front();
                ec = exp_cyc.pop_front();
                if ({bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad} !== e) begin
                    errors++;
                    $display("FAIL sb_result got idx=%0d x=%0d y=%0d sad=%0h expected idx=%0d x=%0d y=%0d sad=%0h",
                             bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad,
                             e[41:38], e[37:35], e[34:32], e[31:0]);
                end
                checks++;
                if (cyc !== ec) begin
                    errors++;
                    $display("FAIL sb_latency got cycle %0d expected cycle %0d", cyc, ec);
                end
            end
        end
    end

    task automatic set_blk(input logic [31:0] s[16]);
        bus.blk0_o  = s[0];  bus.blk1_o  = s[1];  bus.blk2_o  = s[2];  bus.blk3_o  = s[3];
        bus.blk4_o  = s[4];  bus.blk5_o  = s[5];  bus.blk6_o  = s[6];  bus.blk7_o  = s[7];
        bus.blk8_o  = s[8];  bus.blk9_o  = s[9];  bus.blk10_o = s[10]; bus.blk11_o = s[11];
        bus.blk12_o = s[12]; bus.blk13_o = s[13]; bus.blk14_o = s[14]; bus.blk15_o = s[15];
    endtask

    // Drives one blk_ovalid cycle; caller is positioned just after a posedge.
    task automatic drive_set(input logic [31:0] s[16], input bit accepted);
        set_blk(s);
        bus.blk_ovalid = 1'b1;
        if (accepted) begin
            exp_q.push_back(model(s));
            exp_cyc.push_back(cyc + 16);
        end
        @(posedge clk);
        #1;
        bus.blk_ovalid = 1'b0;
    endtask

    task automatic fill(output logic [31:0] s[16], input logic [31:0] v);
        for (int i = 0; i < 16; i++) s[i] = v;
    endtask

    // Waits (bounded) for an mv_vld at a negedge; counts busy cycles seen.
    task automatic wait_result(output bit found, output int busy_n);
        found  = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.mv_vld) found = 1'b1;
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_result timeout at cycle %0d", cyc);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] s[16];
        fill(s, 32'd0);
        set_blk(s);
        bus.blk_ovalid  = 1'b0;
        bus.frame_start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.mv_vld, bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad, bus.busy, bus.drop_cnt, bus.fsm_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs vld=%b idx=%0d x=%0d y=%0d sad=%0h busy=%b drop=%0d state=%0d expected all 0",
                     bus.mv_vld, bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad, bus.busy, bus.drop_cnt, bus.fsm_state);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [31:0] s[16];
        bit found;
        int busy_n;
        fill(s, 32'd100);
        s[5] = 32'd10;
        drive_set(s, 1'b1);
        wait_result(found, busy_n);
        checks++;
        if (busy_n !== 15) begin
            errors++;
            $display("FAIL single_busy_cycles got %0d expected 15", busy_n);
        end
        checks++;
        if ({bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad} !== {4'd5, 3'b111, 3'b111, 32'd10}) begin
            errors++;
            $display("FAIL single_result got idx=%0d x=%b y=%b sad=%0d expected idx=5 x=111 y=111 sad=10",
                     bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad);
        end
        @(negedge clk);
        checks++;
        if (bus.mv_vld !== 1'b0 || bus.mv_idx !== 4'd5) begin
            errors++;
            $display("FAIL single_hold got vld=%b idx=%0d expected vld=0 idx=5", bus.mv_vld, bus.mv_idx);
        end
        wait_drain();
    endtask

    task automatic test_tie();
        logic [31:0] s[16];
        bit found;
        int busy_n;
        fill(s, 32'hFFFF_FFFF);
        s[3]  = 32'd7;
        s[12] = 32'd7;
        drive_set(s, 1'b1);
        wait_result(found, busy_n);
        checks++;
        if ({bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad} !== {4'd3, 3'b001, 3'b110, 32'd7}) begin
            errors++;
            $display("FAIL tie_result got idx=%0d x=%b y=%b sad=%0d expected idx=3 x=001 y=110 sad=7",
                     bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad);
        end
        wait_drain();
    endtask

    task automatic test_unsigned_boundary();
        logic [31:0] s[16];
        bit found;
        int busy_n;
        fill(s, 32'h8000_0000);
        s[15] = 32'h7FFF_FFFF;
        drive_set(s, 1'b1);
        wait_result(found, busy_n);
        checks++;
        if ({bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad} !== {4'd15, 3'b001, 3'b001, 32'h7FFF_FFFF}) begin
            errors++;
            $display("FAIL boundary_result got idx=%0d x=%b y=%b sad=%0h expected idx=15 x=001 y=001 sad=7fffffff",
                     bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[16];
        logic [31:0] b[16];
        fill(a, 32'd50);
        a[0] = 32'd1;
        fill(b, 32'd20);
        b[10] = 32'd2;
        drive_set(a, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (bus.fsm_state !== 2'd2 || bus.mv_vld !== 1'b1) begin
            errors++;
            $display("FAIL b2b_out_cycle got state=%0d vld=%b expected state=2 vld=1", bus.fsm_state, bus.mv_vld);
        end
        drive_set(b, 1'b1);
        wait_drain();
        checks++;
        if (bus.drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL b2b_drop_cnt got %0d expected 0", bus.drop_cnt);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] a[16];
        logic [31:0] z[16];
        bit found;
        int busy_n;
        fill(a, 32'd50);
        a[9] = 32'd3;
        fill(z, 32'd0);
        drive_set(a, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        drive_set(z, 1'b0);
        wait_result(found, busy_n);
        checks++;
        if ({bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad} !== {4'd9, 3'b111, 3'b000, 32'd3}) begin
            errors++;
            $display("FAIL overrun_result got idx=%0d x=%b y=%b sad=%0d expected idx=9 x=111 y=000 sad=3",
                     bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad);
        end
        checks++;
        if (bus.drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL overrun_drop_cnt got %0d expected 1", bus.drop_cnt);
        end
        wait_drain();
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        checks++;
        if (bus.drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL frame_clear got %0d expected 0", bus.drop_cnt);
        end
    endtask

    task automatic test_frame_coincident();
        logic [31:0] d[16];
        logic [31:0] z[16];
        fill(d, 32'd9);
        d[14] = 32'd1;
        fill(z, 32'd0);
        drive_set(d, 1'b1);
        drive_set(z, 1'b0);
        drive_set(z, 1'b0);
        drive_set(z, 1'b0);
        checks++;
        if (bus.drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL drop_count3 got %0d expected 3", bus.drop_cnt);
        end
        bus.frame_start = 1'b1;
        drive_set(z, 1'b0);
        bus.frame_start = 1'b0;
        checks++;
        if (bus.drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL frame_with_drop got %0d expected 1", bus.drop_cnt);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] e[16];
        logic [31:0] f[16];
        fill(e, 32'd40);
        e[6] = 32'd4;
        drive_set(e, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mv_vld, bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad, bus.busy, bus.drop_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset vld=%b idx=%0d x=%0d y=%0d sad=%0h busy=%b drop=%0d expected all 0",
                     bus.mv_vld, bus.mv_idx, bus.mv_x, bus.mv_y, bus.min_sad, bus.busy, bus.drop_cnt);
        end
        exp_q.delete();
        exp_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) f[i] = 32'($urandom_range(5, 60));
        drive_set(f, 1'b1);
        wait_drain();
    endtask

    task automatic test_random();
        logic [31:0] s[16];
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) s[i] = 32'($urandom_range(0, 7));
            drive_set(s, 1'b1);
            if (n % 2 == 0) begin
                repeat (15) @(posedge clk);
                #1;
            end else begin
                repeat (16 + $urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        bus.blk_ovalid  = 1'b0;
        bus.frame_start = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_unsigned_boundary();
        test_back_to_back();
        test_overrun();
        test_frame_coincident();
        test_reset_mid_scan();
        test_random();
        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mv_select.md
Name: mv_select

Overview:
- Sits directly downstream of pe_top and consumes its 16 candidate SAD results (blk_ovalid, blk0_o..blk15_o).
- Captures one candidate set per blk_ovalid pulse and scans it serially to find the minimum SAD and its index.
- Maps that index to a signed motion vector (mv_x, mv_y) on a 4x4 search grid and emits a one-cycle result strobe.
- Counts input sets dropped because the block was busy, per frame.

Parameters:
- SAD_W, 32: width of each SAD candidate and of min_sad.
- GRID_W, 4: search grid width. Candidate index idx = row*GRID_W + col. Fixed 16 candidates.
- MV_OFS, 2: centre offset. mv_x = col - MV_OFS, mv_y = row - MV_OFS.
- CNT_W, 16: width of drop_cnt.

Ports:
- clk  in  1  pixel/processing clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at frame start (driven from ref_gen vsync_start); clears drop_cnt
- blk_ovalid  in  1  one-cycle strobe: blk0_o..blk15_o valid this cycle
- blk0_o..blk15_o  in  SAD_W each  SAD of candidates 0..15 (16 separate ports)
- mv_vld  out  1  one-cycle strobe: result outputs valid
- mv_idx  out  4  index of winning candidate
- mv_x  out  3  signed two's-complement horizontal MV
- mv_y  out  3  signed two's-complement vertical MV
- min_sad  out  SAD_W  winning SAD value
- busy  out  1  high while a candidate set is held or being scanned
- drop_cnt  out  CNT_W  saturating count of sets dropped since the last frame_start

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0; capture bank 0; running min 0; index 0.
- FSM states: IDLE, SCAN, OUT.
  - IDLE + blk_ovalid: latch all 16 SADs into the capture bank; load running min = blk0_o and running idx = 0; go to SCAN with scan counter k = 1.
  - SCAN: each cycle compare bank[k] against the running min. Replace only when bank[k] is strictly less, so ties keep the lower index. Increment k. After k = 15 is processed, go to OUT.
  - OUT: mv_vld = 1 for exactly one cycle. mv_idx, mv_x, mv_y and min_sad present the result. Next state is IDLE, or SCAN if blk_ovalid is high in this cycle (that set is accepted as from IDLE).
- Latency: blk_ovalid at cycle T gives SCAN at T+1..T+15 and mv_vld at T+16. Minimum initiation interval is 16 cycles.
- Result outputs hold their values until the next OUT. mv_vld is low in all other cycles.
- busy = 1 in SCAN; 0 in IDLE and OUT.
- Drop rule: blk_ovalid while in SCAN is ignored and drop_cnt increments. The capture bank is not disturbed.
- drop_cnt saturates at 2^CNT_W - 1.
- frame_start:
  - Sets drop_cnt to 0.
  - If frame_start and a drop occur in the same cycle, drop_cnt becomes 1.
  - Does not abort a scan in progress.
- MV mapping:
  - col = idx % GRID_W, row = idx / GRID_W.
  - mv_x = col - MV_OFS and mv_y = row - MV_OFS, computed as 3-bit signed. With the default parameters the range is -2..+1.
- SAD values are unsigned; comparisons are unsigned and full SAD_W wide.
- Equal SADs everywhere: idx 0 wins.
- Reset mid-scan: outputs return to 0 immediately. No mv_vld is emitted for the aborted set.

Test Plan:
1. Single set, blk5_o = 10, all others 100 -> mv_vld exactly 16 cycles after blk_ovalid; mv_idx = 5, mv_x = -1, mv_y = -1, min_sad = 10; busy high for 15 cycles.
2. Tie: blk3_o = blk12_o = 7, others 0xFFFFFFFF -> mv_idx = 3, mv_x = +1, mv_y = -2, min_sad = 7.
3. All SADs = 0x80000000 except blk15_o = 0x7FFFFFFF (unsigned boundary) -> mv_idx = 15, mv_x = +1, mv_y = +1.
4. Back-to-back: second blk_ovalid in the OUT cycle -> accepted; its mv_vld follows 16 cycles later; drop_cnt stays 0.
5. Overrun: blk_ovalid at T and again at T+4 (during SCAN) -> first result is correct and unaffected; drop_cnt = 1; frame_start pulse -> drop_cnt = 0. frame_start coincident with a drop -> drop_cnt = 1.
6. rst_n asserted at T+8 mid-scan -> all outputs 0 asynchronously; no mv_vld after release; a new set then completes normally.
